// File: rtl/ds3231_uart_set.sv
// ds3231_uart_set: parses a UART time-set frame and forwards it to the DS3231 I2C top.
// The frame is HDR_BYTE, six BCD bytes (year, month, date, hour, minutes, seconds),
// then a checksum byte equal to the XOR of the six data bytes.
// A valid frame raises write_start_uart until write_over_uart, then ACKs (8'h06).
// A rejected frame (bad checksum, inter-byte timeout, or failed range check) NAKs (8'h15).
// Optional feature macro: DS_BCD_CHECK_EN enables BCD nibble and field range checks.
module ds3231_uart_set #(
    parameter int         TIMEOUT_CYC = 500000,
    parameter logic [7:0] HDR_BYTE    = 8'hA5
) (
    input  logic        clk_50m,
    input  logic        rst,
    input  logic [7:0]  rx_dat,
    input  logic        rx_valid,
    output logic        write_start_uart,
    output logic [47:0] write_dat_uart,
    input  logic        write_over_uart,
    output logic [7:0]  tx_dat,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        frame_err
);

    localparam logic [7:0]  ACK_BYTE = 8'h06;
    localparam logic [7:0]  NAK_BYTE = 8'h15;
    localparam logic [19:0] GAP_LAST = 20'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        CHK,
        WRITE,
        REPLY
    } state_t;

    state_t      state_reg;
    logic [47:0] shadow_reg;
    logic [7:0]  chk_reg;
    logic [2:0]  idx_reg;
    logic [19:0] gap_reg;
    logic        range_ok;
    logic        gap_expired;

    assign gap_expired = (gap_reg == GAP_LAST);

`ifdef DS_BCD_CHECK_EN
    // Every nibble of the captured frame must be a decimal digit.
    logic [11:0] nib_ok;
    generate
        for (genvar gi = 0; gi < 12; gi++) begin : g_nib
            assign nib_ok[gi] = (shadow_reg[gi*4 +: 4] <= 4'd9);
        end
    endgenerate

    // Field layout in the shadow register: year, month, date, hour, minutes, seconds.
    logic [7:0] month_b, date_b, hour_b, min_b, sec_b;
    assign month_b = shadow_reg[39:32];
    assign date_b  = shadow_reg[31:24];
    assign hour_b  = shadow_reg[23:16];
    assign min_b   = shadow_reg[15:8];
    assign sec_b   = shadow_reg[7:0];

    assign range_ok = (&nib_ok)
                    && (sec_b  <= 8'h59)
                    && (min_b  <= 8'h59)
                    && (hour_b <= 8'h23)
                    && (date_b >= 8'h01) && (date_b <= 8'h31)
                    && (month_b >= 8'h01) && (month_b <= 8'h12);
`else
    assign range_ok = 1'b1;
`endif

    // Frame parser, RTC request handshake and reply generation.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_reg        <= IDLE;
            shadow_reg       <= 48'h0;
            chk_reg          <= 8'h00;
            idx_reg          <= 3'd0;
            gap_reg          <= 20'd0;
            write_start_uart <= 1'b0;
            write_dat_uart   <= 48'h0;
            tx_dat           <= 8'h00;
            tx_valid         <= 1'b0;
            frame_err        <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (rx_valid && rx_dat == HDR_BYTE) begin
                        state_reg <= DATA;
                        idx_reg   <= 3'd0;
                        chk_reg   <= 8'h00;
                        gap_reg   <= 20'd0;
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        // A received byte always beats a simultaneous timeout.
                        shadow_reg <= {shadow_reg[39:0], rx_dat};
                        chk_reg    <= chk_reg ^ rx_dat;
                        gap_reg    <= 20'd0;
                        idx_reg    <= idx_reg + 3'd1;
                        if (idx_reg == 3'd5) begin
                            state_reg <= CHK;
                        end
                    end else if (gap_expired) begin
                        frame_err <= 1'b1;
                        tx_dat    <= NAK_BYTE;
                        tx_valid  <= 1'b1;
                        state_reg <= REPLY;
                    end else begin
                        gap_reg <= gap_reg + 20'd1;
                    end
                end
                CHK: begin
                    if (rx_valid) begin
                        gap_reg <= 20'd0;
                        if (rx_dat == chk_reg && range_ok) begin
                            write_dat_uart   <= shadow_reg;
                            write_start_uart <= 1'b1;
                            state_reg        <= WRITE;
                        end else begin
                            frame_err <= 1'b1;
                            tx_dat    <= NAK_BYTE;
                            tx_valid  <= 1'b1;
                            state_reg <= REPLY;
                        end
                    end else if (gap_expired) begin
                        frame_err <= 1'b1;
                        tx_dat    <= NAK_BYTE;
                        tx_valid  <= 1'b1;
                        state_reg <= REPLY;
                    end else begin
                        gap_reg <= gap_reg + 20'd1;
                    end
                end
                WRITE: begin
                    // Incoming bytes are dropped while the RTC write is in flight.
                    if (write_over_uart) begin
                        write_start_uart <= 1'b0;
                        tx_dat           <= ACK_BYTE;
                        tx_valid         <= 1'b1;
                        state_reg        <= REPLY;
                    end
                end
                REPLY: begin
                    // tx_dat stays put until the transmitter takes it.
                    if (tx_ready) begin
                        tx_valid  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ds3231_uart_set.sv
// Testbench for ds3231_uart_set: frame-level reference model checked every cycle,
// plus directed frames with hand-computed expectations.
module tb_ds3231_uart_set;

    localparam int         T   = 40;
    localparam logic [7:0] HDR = 8'hA5;

    logic        clk_50m          = 1'b0;
    logic        rst              = 1'b1;
    logic [7:0]  rx_dat           = 8'h00;
    logic        rx_valid         = 1'b0;
    logic        write_start_uart;
    logic [47:0] write_dat_uart;
    logic        write_over_uart  = 1'b0;
    logic [7:0]  tx_dat;
    logic        tx_valid;
    logic        tx_ready         = 1'b1;
    logic        frame_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #10 clk_50m = ~clk_50m;

    ds3231_uart_set #(
        .TIMEOUT_CYC(T),
        .HDR_BYTE   (HDR)
    ) dut (
        .clk_50m         (clk_50m),
        .rst             (rst),
        .rx_dat          (rx_dat),
        .rx_valid        (rx_valid),
        .write_start_uart(write_start_uart),
        .write_dat_uart  (write_dat_uart),
        .write_over_uart (write_over_uart),
        .tx_dat          (tx_dat),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .frame_err       (frame_err)
    );

    task automatic cmp(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    logic        m_collect = 1'b0;   // header seen, gathering data + checksum
    logic        m_write   = 1'b0;   // request outstanding to RTC
    logic        m_reply   = 1'b0;   // reply byte pending
    logic        m_err     = 1'b0;
    logic [7:0]  m_tx      = 8'h00;
    logic [47:0] m_dat     = 48'h0;
    logic [7:0]  m_q[$];
    int          m_gap     = 0;      // idle cycles since the last frame byte

    function automatic bit bcd_in(input logic [7:0] b, input int lo, input int hi);
        int v;
        if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return 1'b0;
        v = int'(b[7:4]) * 10 + int'(b[3:0]);
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic bit model_accepts(input logic [7:0] c);
        logic [7:0] x;
        x = 8'h00;
        foreach (m_q[i]) x ^= m_q[i];
        if (x != c) return 1'b0;
`ifdef DS_BCD_CHECK_EN
        return bcd_in(m_q[0], 0, 99) && bcd_in(m_q[1], 1, 12) && bcd_in(m_q[2], 1, 31)
            && bcd_in(m_q[3], 0, 23) && bcd_in(m_q[4], 0, 59) && bcd_in(m_q[5], 0, 59);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [7:0] xor48(input logic [47:0] d);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 6; i++) x ^= d[i*8 +: 8];
        return x;
    endfunction

    task automatic model_nak();
        m_collect = 1'b0;
        m_reply   = 1'b1;
        m_tx      = 8'h15;
        m_err     = 1'b1;
    endtask

    // Advance the model once per clock using the inputs the DUT sees.
    always @(posedge clk_50m) begin
        m_err = 1'b0;
        if (rst) begin
            m_collect = 1'b0; m_write = 1'b0; m_reply = 1'b0;
            m_tx = 8'h00; m_dat = 48'h0; m_gap = 0; m_q.delete();
        end else if (m_reply) begin
            if (tx_ready) m_reply = 1'b0;
        end else if (m_write) begin
            if (write_over_uart) begin
                m_write = 1'b0; m_reply = 1'b1; m_tx = 8'h06;
            end
        end else if (!m_collect) begin
            if (rx_valid && rx_dat == HDR) begin
                m_collect = 1'b1; m_gap = 0; m_q.delete();
            end
        end else if (rx_valid) begin
            m_gap = 0;
            if (m_q.size() < 6) begin
                m_q.push_back(rx_dat);
            end else if (model_accepts(rx_dat)) begin
                m_collect = 1'b0;
                m_write   = 1'b1;
                m_dat     = {m_q[0], m_q[1], m_q[2], m_q[3], m_q[4], m_q[5]};
            end else begin
                model_nak();
            end
        end else if (m_gap == T - 1) begin
            model_nak();
        end else begin
            m_gap++;
        end
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clk_50m) begin
        cmp("write_start_uart", write_start_uart, m_write);
        cmp("write_dat_uart", write_dat_uart, m_dat);
        cmp("tx_valid", tx_valid, m_reply);
        cmp("tx_dat", tx_dat, m_tx);
        cmp("frame_err", frame_err, m_err);
    end

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] b);
        rx_dat   = b;
        rx_valid = 1'b1;
        @(negedge clk_50m);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] d, input logic [7:0] c);
        $display("frame data=%h chk=%h", d, c);
        send_byte(HDR);
        for (int i = 5; i >= 0; i--) send_byte(d[i*8 +: 8]);
        send_byte(c);
    endtask

    // Hold the RTC request for 'hold' cycles, then complete it and expect a one-cycle ACK.
    task automatic do_ack(input string tag, input int hold);
        for (int i = 0; i < hold; i++) begin
            cmp({tag, "_ws_hold"}, write_start_uart, 1'b1);
            if (i == hold - 1) write_over_uart = 1'b1;
            @(negedge clk_50m);
        end
        write_over_uart = 1'b0;
        cmp({tag, "_ws_fall"}, write_start_uart, 1'b0);
        cmp({tag, "_ack_valid"}, tx_valid, 1'b1);
        cmp({tag, "_ack_dat"}, tx_dat, 8'h06);
        @(negedge clk_50m);
        cmp({tag, "_ack_done"}, tx_valid, 1'b0);
    endtask

    localparam logic [47:0] FA = 48'h240517134530;
    localparam logic [47:0] FB = 48'h991231235959;
    localparam logic [47:0] FH = 48'h240517244530;
    localparam logic [47:0] FD = 48'h210615081530;

    initial begin
        int seen;
        repeat (3) @(negedge clk_50m);
        cmp("reset_ws", write_start_uart, 1'b0);
        cmp("reset_dat", write_dat_uart, 48'h0);
        cmp("reset_tx_valid", tx_valid, 1'b0);
        cmp("reset_tx_dat", tx_dat, 8'h00);
        cmp("reset_frame_err", frame_err, 1'b0);
        rst = 1'b0;
        @(negedge clk_50m);

        // XOR of 24,05,17,13,45,30 is 0x50
        cmp("xor_A", xor48(FA), 8'h50);

        // write_over_uart in IDLE must not produce a reply
        write_over_uart = 1'b1;
        @(negedge clk_50m);
        write_over_uart = 1'b0;
        @(negedge clk_50m);
        cmp("idle_over_ignored", tx_valid, 1'b0);

        // Valid frame, completion 10 cycles after the request rises
        send_frame(FA, 8'h50);
        cmp("A_dat", write_dat_uart, 48'h240517134530);
        do_ack("A", 10);

        // Bad checksum
        send_frame(FA, 8'h49);
        cmp("badchk_err", frame_err, 1'b1);
        cmp("badchk_valid", tx_valid, 1'b1);
        cmp("badchk_dat", tx_dat, 8'h15);
        cmp("badchk_ws", write_start_uart, 1'b0);
        @(negedge clk_50m);
        cmp("badchk_err_width", frame_err, 1'b0);
        cmp("badchk_done", tx_valid, 1'b0);

        // Header plus three bytes, then silence
        $display("partial frame then silence");
        send_byte(HDR);
        send_byte(8'h24); send_byte(8'h05); send_byte(8'h17);
        seen = -1;
        for (int j = 1; j <= T + 5; j++) begin
            if (frame_err && seen < 0) seen = j;
            @(negedge clk_50m);
        end
        cmp("timeout_cycle", seen, T + 1);
        cmp("timeout_dat", tx_dat, 8'h15);

        // Following valid frame is accepted
        send_frame(FA, xor48(FA));
        do_ack("after_to", 3);

        // Byte arriving on the exact timeout cycle wins
        $display("frame data=%h with byte on timeout edge", FB);
        send_byte(HDR);
        send_byte(FB[47:40]);
        repeat (T - 1) @(negedge clk_50m);
        for (int i = 4; i >= 0; i--) send_byte(FB[i*8 +: 8]);
        send_byte(xor48(FB));
        cmp("edge_ws", write_start_uart, 1'b1);
        cmp("edge_dat", write_dat_uart, 48'h991231235959);
        do_ack("edge", 2);

        // Hour 0x24 with a correct checksum
        send_frame(FH, xor48(FH));
`ifdef DS_BCD_CHECK_EN
        cmp("hour24_err", frame_err, 1'b1);
        cmp("hour24_nak", tx_dat, 8'h15);
        cmp("hour24_ws", write_start_uart, 1'b0);
        @(negedge clk_50m);
`else
        cmp("hour24_dat", write_dat_uart, 48'h240517244530);
        do_ack("hour24", 2);
`endif

        // Reset while the request is outstanding
        send_frame(FA, xor48(FA));
        repeat (3) @(negedge clk_50m);
        $display("reset during WRITE");
        rst = 1'b1;
        @(negedge clk_50m);
        rst = 1'b0;
        cmp("rstw_ws", write_start_uart, 1'b0);
        cmp("rstw_dat", write_dat_uart, 48'h0);
        write_over_uart = 1'b1;
        @(negedge clk_50m);
        write_over_uart = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmp("rstw_no_reply", tx_valid, 1'b0);
            @(negedge clk_50m);
        end

        // Bytes during WRITE are dropped; 50-cycle transmitter stall
        send_frame(FB, xor48(FB));
        $display("bytes during WRITE, then tx stall");
        send_byte(HDR); send_byte(8'h11); send_byte(8'h22);
        cmp("drop_ws", write_start_uart, 1'b1);
        tx_ready = 1'b0;
        write_over_uart = 1'b1;
        @(negedge clk_50m);
        write_over_uart = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cmp("stall_valid", tx_valid, 1'b1);
            cmp("stall_dat", tx_dat, 8'h06);
            @(negedge clk_50m);
        end
        tx_ready = 1'b1;
        @(negedge clk_50m);
        cmp("stall_done", tx_valid, 1'b0);

        // Fresh frame after the stall
        send_frame(FD, xor48(FD));
        cmp("D_dat", write_dat_uart, 48'h210615081530);
        do_ack("D", 4);

        repeat (3) @(negedge clk_50m);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
